fir_coeff_bank_ctrl: RTL and testbench

//   Double-buffered coefficient manager for fir_transposed. Accepts a new tap set

---
 rtl/fir_coeff_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_fir_coeff_bank_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_bank_ctrl.sv
// Double-buffered FIR coefficient bank: loads a tap set into the shadow bank, then swaps it in
// on a sample strobe. Optional macro COEF_SYM_EN enables half-length linear-phase loading.
module fir_coeff_bank_ctrl #(
    parameter int unsigned N      = 39,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_tvalid,
    output logic                  cfg_tready,
    input  logic [COEF_W-1:0]     cfg_tdata,
    input  logic                  cfg_tlast,
    input  logic                  sample_vld,
    output logic [N*COEF_W-1:0]   h_flat,
    output logic                  bank_sel,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  err_len,
    output logic [CNT_W-1:0]      swap_cnt
);

`ifdef COEF_SYM_EN
    localparam int unsigned LEN = (N + 1) / 2;
`else
    localparam int unsigned LEN = N;
`endif
    localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StPending} state_t;

    state_t              state;
    logic [IDX_W-1:0]    wr_idx;
    logic [COEF_W-1:0]   bank [2][N];
    logic                swap_pend;
    logic                accept;
    logic                loading;
    logic                at_end;

    assign accept     = cfg_tvalid && cfg_tready;
    assign loading    = accept && ((state == StIdle) || (state == StLoad));
    assign at_end     = (wr_idx == IDX_W'(LEN - 1));
    // Ready is forced low while reset is asserted, not just after the first edge.
    assign cfg_tready = rst_n && (state != StPending);
    assign busy       = (state != StIdle);

    always_comb begin
        h_flat = '0;
        for (int k = 0; k < int'(N); k++) begin
            h_flat[k*COEF_W +: COEF_W] = bank[bank_sel][k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            wr_idx    <= '0;
            bank_sel  <= 1'b0;
            swap_pend <= 1'b0;
            swap_done <= 1'b0;
            err_len   <= 1'b0;
            swap_cnt  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < int'(N); k++) begin
                    bank[b][k] <= '0;
                end
            end
        end else begin
            err_len   <= 1'b0;
            swap_pend <= 1'b0;
            swap_done <= swap_pend;
            if (swap_pend) begin
                swap_cnt <= swap_cnt + CNT_W'(1);
            end

            // Only the shadow bank is ever written.
            for (int k = 0; k < int'(N); k++) begin
`ifdef COEF_SYM_EN
                if (loading && ((k == int'(wr_idx)) || (k == int'(N) - 1 - int'(wr_idx)))) begin
`else
                if (loading && (k == int'(wr_idx))) begin
`endif
                    bank[~bank_sel][k] <= cfg_tdata;
                end
            end

            unique case (state)
                StIdle, StLoad: begin
                    if (accept) begin
                        if (at_end) begin
                            wr_idx  <= '0;
                            err_len <= !cfg_tlast;
                            state   <= cfg_tlast ? StPending : StDrain;
                        end else if (cfg_tlast) begin
                            wr_idx  <= '0;
                            err_len <= 1'b1;
                            state   <= StIdle;
                        end else begin
                            wr_idx  <= wr_idx + IDX_W'(1);
                            state   <= StLoad;
                        end
                    end
                end
                StDrain: begin
                    if (accept && cfg_tlast) begin
                        state <= StIdle;
                    end
                end
                StPending: begin
                    if (sample_vld) begin
                        bank_sel  <= ~bank_sel;
                        swap_pend <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Directed bench for fir_coeff_bank_ctrl with N=9; the symmetric-load case runs when
// COEF_SYM_EN is defined.
module tb_fir_coeff_bank_ctrl;
    localparam int unsigned N      = 9;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HW     = N * COEF_W;

    logic              clk;
    logic              rst_n;
    logic              cfg_tvalid;
    logic              cfg_tready;
    logic [COEF_W-1:0] cfg_tdata;
    logic              cfg_tlast;
    logic              sample_vld;
    logic [HW-1:0]     h_flat;
    logic              bank_sel;
    logic              busy;
    logic              swap_done;
    logic              err_len;
    logic [CNT_W-1:0]  swap_cnt;

    int checks = 0;
    int errors = 0;

    logic [COEF_W-1:0] set_a [N];
    logic [HW-1:0]     exp_a;
    logic [HW-1:0]     exp_b;
    logic [HW-1:0]     exp_c;

    fir_coeff_bank_ctrl #(.N(N), .COEF_W(COEF_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .cfg_tdata  (cfg_tdata),
        .cfg_tlast  (cfg_tlast),
        .sample_vld (sample_vld),
        .h_flat     (h_flat),
        .bank_sel   (bank_sel),
        .busy       (busy),
        .swap_done  (swap_done),
        .err_len    (err_len),
        .swap_cnt   (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [COEF_W-1:0] d, input logic last, input logic sv);
        cfg_tvalid = 1'b1;
        cfg_tdata  = d;
        cfg_tlast  = last;
        sample_vld = sv;
        step();
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        sample_vld = 1'b0;
    endtask

    task automatic strobe();
        sample_vld = 1'b1;
        step();
        sample_vld = 1'b0;
    endtask

    initial begin
        set_a = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
                  16'h1496, 16'h1089, 16'h0AE4, 16'h04F6};
        for (int k = 0; k < int'(N); k++) begin
            exp_a[k*COEF_W +: COEF_W] = set_a[k];
            exp_b[k*COEF_W +: COEF_W] = 16'h0100 + 16'(k);
            exp_c[k*COEF_W +: COEF_W] = 16'hF000 + 16'(k);
        end
        cfg_tvalid = 1'b0;
        cfg_tdata  = '0;
        cfg_tlast  = 1'b0;
        sample_vld = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #1;
        check("rst_tready", 256'(cfg_tready), 256'(0));
        check("rst_h_flat", 256'(h_flat), 256'(0));
        check("rst_bank_sel", 256'(bank_sel), 256'(0));
        check("rst_swap_cnt", 256'(swap_cnt), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rel_tready", 256'(cfg_tready), 256'(1));
        check("rel_swap_done", 256'(swap_done), 256'(0));

`ifndef COEF_SYM_EN
        // Full 9-beat load, hold off the swap, then strobe.
        for (int i = 0; i < int'(N); i++) begin
            send_beat(set_a[i], (i == int'(N) - 1), 1'b0);
            if (i == 0) check("load_busy", 256'(busy), 256'(1));
        end
        check("pend_busy", 256'(busy), 256'(1));
        check("pend_tready", 256'(cfg_tready), 256'(0));
        step();
        step();
        check("noswap_bank_sel", 256'(bank_sel), 256'(0));
        check("noswap_h_flat", 256'(h_flat), 256'(0));
        strobe();
        check("swap_bank_sel", 256'(bank_sel), 256'(1));
        check("swap_tap4", 256'(h_flat[4*COEF_W +: COEF_W]), 256'(16'h160F));
        check("swap_h_flat", 256'(h_flat), 256'(exp_a));
        check("swap_done_early", 256'(swap_done), 256'(0));
        check("swap_idle", 256'(busy), 256'(0));
        step();
        check("swap_done", 256'(swap_done), 256'(1));
        check("swap_cnt1", 256'(swap_cnt), 256'(1));
        step();
        check("swap_done_clr", 256'(swap_done), 256'(0));

        // Short set: tlast on beat 5.
        for (int i = 1; i <= 5; i++) send_beat(16'h1111 * 16'(i), (i == 5), 1'b0);
        check("short_err", 256'(err_len), 256'(1));
        check("short_idle", 256'(busy), 256'(0));
        step();
        check("short_err_clr", 256'(err_len), 256'(0));
        strobe();
        check("short_bank_sel", 256'(bank_sel), 256'(1));
        check("short_h_flat", 256'(h_flat), 256'(exp_a));
        step();
        check("short_cnt", 256'(swap_cnt), 256'(1));

        // Long set: error at beat 9, beats 10-12 drained.
        for (int i = 1; i <= 12; i++) begin
            send_beat(16'h2000 + 16'(i), (i == 12), 1'b0);
            if (i == 9) begin
                check("long_err", 256'(err_len), 256'(1));
                check("long_drain", 256'(busy), 256'(1));
            end
            if (i == 10) check("long_err_clr", 256'(err_len), 256'(0));
        end
        check("long_idle", 256'(busy), 256'(0));
        check("long_err_end", 256'(err_len), 256'(0));
        for (int i = 0; i < int'(N); i++) send_beat(16'h0100 + 16'(i), (i == int'(N) - 1), 1'b0);
        check("b_no_err", 256'(err_len), 256'(0));
        strobe();
        check("b_bank_sel", 256'(bank_sel), 256'(0));
        check("b_h_flat", 256'(h_flat), 256'(exp_b));
        step();
        check("b_cnt", 256'(swap_cnt), 256'(2));

        // Strobe coincident with final tlast must not commit.
        for (int i = 0; i < int'(N); i++) begin
            send_beat(16'hF000 + 16'(i), (i == int'(N) - 1), (i == int'(N) - 1));
        end
        check("coinc_bank_sel", 256'(bank_sel), 256'(0));
        check("coinc_busy", 256'(busy), 256'(1));
        step();
        check("coinc_hold", 256'(bank_sel), 256'(0));
        strobe();
        check("c_bank_sel", 256'(bank_sel), 256'(1));
        check("c_h_flat", 256'(h_flat), 256'(exp_c));
        step();
        check("c_cnt", 256'(swap_cnt), 256'(3));

        // Reset while PENDING discards the set.
        for (int i = 0; i < int'(N); i++) send_beat(set_a[i], (i == int'(N) - 1), 1'b0);
        check("pend2_tready", 256'(cfg_tready), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        check("prst_h_flat", 256'(h_flat), 256'(0));
        check("prst_bank_sel", 256'(bank_sel), 256'(0));
        check("prst_cnt", 256'(swap_cnt), 256'(0));
        check("prst_busy", 256'(busy), 256'(0));
        step();
        rst_n = 1'b1;
        strobe();
        check("prst_noswap", 256'(bank_sel), 256'(0));
        step();
        check("prst_no_done", 256'(swap_done), 256'(0));
`else
        // Symmetric load: 5 beats fill all 9 taps.
        for (int i = 0; i < 5; i++) send_beat(set_a[i], (i == 4), 1'b0);
        check("sym_err", 256'(err_len), 256'(0));
        check("sym_pend", 256'(busy), 256'(1));
        strobe();
        check("sym_bank_sel", 256'(bank_sel), 256'(1));
        check("sym_tap8", 256'(h_flat[8*COEF_W +: COEF_W]), 256'(16'h04F6));
        check("sym_tap5", 256'(h_flat[5*COEF_W +: COEF_W]), 256'(16'h1496));
        check("sym_h_flat", 256'(h_flat), 256'(exp_a));
        step();
        check("sym_cnt", 256'(swap_cnt), 256'(1));
        for (int i = 0; i < 5; i++) send_beat(16'h0123, 1'b0, 1'b0);
        check("sym_long_err", 256'(err_len), 256'(1));
        check("sym_drain", 256'(busy), 256'(1));
        send_beat(16'h0123, 1'b1, 1'b0);
        check("sym_drain_end", 256'(busy), 256'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
